instr_sequencer: RTL and testbench



---
 rtl/instr_seq_pkg.sv | 19 +
 rtl/instr_sequencer_prog_mem.sv | 27 ++
 rtl/instr_sequencer.sv | 174 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instruction sequencer feeding the ALU.
package instr_seq_pkg;

    localparam int unsigned IW = 16;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } prog_word_t;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: one synchronous write port, one asynchronous read port.
module instr_sequencer_prog_mem
    import instr_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  prog_word_t       wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output prog_word_t       rdata_o
);

    prog_word_t mem_q [DEPTH];

    // Contents are only meaningful once loaded, so no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Issues a host-loaded program of {instr, d0, d1} words to the ALU under valid/ready.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [IW-1:0] load_instr_i,
    input  logic [DW-1:0] load_d0_i,
    input  logic [DW-1:0] load_d1_i,
    input  logic          start_i,
    input  logic [AW:0]   prog_len_i,
    input  logic          abort_i,
    input  logic          exec_ready_i,
    output logic [IW-1:0] instruction_o,
    output logic [DW-1:0] data0_o,
    output logic [DW-1:0] data1_o,
    output logic          issue_valid_o,
    output logic [AW-1:0] pc_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [AW:0] DepthLen = (AW+1)'(DEPTH);

    seq_state_e state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    prog_word_t    word_q, word_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          start_ok;
    logic          xfer;
    logic          last;
    logic          mem_we;
    logic [AW:0]   len_clamped;
    logic [AW-1:0] rd_addr;
    prog_word_t    rd_word;
    prog_word_t    wr_word;

    assign start_ok    = start_i && !abort_i && (state_q != StRun);
    assign xfer        = (state_q == StRun) && valid_q && exec_ready_i && !abort_i;
    assign last        = ({1'b0, pc_q} == (len_q - 1'b1));
    assign len_clamped = (prog_len_i > DepthLen) ? DepthLen : prog_len_i;
    // Loads are locked out while running and on the cycle a start is taken.
    assign mem_we      = load_en_i && !abort_i && (state_q != StRun) && !start_ok;
    assign rd_addr     = start_ok ? '0 : (pc_q + 1'b1);
    assign wr_word     = '{instr: load_instr_i, d0: load_d0_i, d1: load_d1_i};

    instr_sequencer_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (load_addr_i),
        .wdata_i (wr_word),
        .raddr_i (rd_addr),
        .rdata_o (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            len_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_ok) begin
                        state_d = (len_clamped == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (xfer && last) begin
                        state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        pc_d    = pc_q;
        len_d   = len_q;
        word_d  = word_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (abort_i) begin
            pc_d    = '0;
            len_d   = '0;
            word_d  = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_ok) begin
                        len_d = len_clamped;
                        pc_d  = '0;
                        if (len_clamped == '0) begin
                            word_d  = '0;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            word_d  = rd_word;
                            valid_d = 1'b1;
                            busy_d  = 1'b1;
                            done_d  = 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (xfer) begin
                        if (last) begin
                            word_d  = '0;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            pc_d   = pc_q + 1'b1;
                            word_d = rd_word;
                        end
                    end
                end
                default: begin
                    pc_d    = '0;
                    word_d  = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign instruction_o = word_q.instr;
    assign data0_o       = word_q.d0;
    assign data1_o       = word_q.d1;
    assign issue_valid_o = valid_q;
    assign pc_o          = pc_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with hand-computed expected words.
module tb_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_instr;
    logic [7:0]  load_d0;
    logic [7:0]  load_d1;
    logic        start;
    logic [4:0]  prog_len;
    logic        abort;
    logic        exec_ready;
    logic [15:0] instruction;
    logic [7:0]  data0;
    logic [7:0]  data1;
    logic        issue_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_instr [16];
    logic [7:0]  m_d0    [16];
    logic [7:0]  m_d1    [16];

    instr_sequencer #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_en_i     (load_en),
        .load_addr_i   (load_addr),
        .load_instr_i  (load_instr),
        .load_d0_i     (load_d0),
        .load_d1_i     (load_d1),
        .start_i       (start),
        .prog_len_i    (prog_len),
        .abort_i       (abort),
        .exec_ready_i  (exec_ready),
        .instruction_o (instruction),
        .data0_o       (data0),
        .data1_o       (data1),
        .issue_valid_o (issue_valid),
        .pc_o          (pc),
        .busy_o        (busy),
        .done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic v, input logic [3:0] p,
                              input logic [15:0] ins, input logic [7:0] a, input logic [7:0] b);
        check_eq({tag, "_valid"}, 32'(issue_valid), 32'(v));
        check_eq({tag, "_pc"},    32'(pc),          32'(p));
        check_eq({tag, "_instr"}, 32'(instruction), 32'(ins));
        check_eq({tag, "_d0"},    32'(data0),       32'(a));
        check_eq({tag, "_d1"},    32'(data1),       32'(b));
    endtask

    task automatic check_flags(input string tag, input logic bz, input logic dn);
        check_eq({tag, "_busy"}, 32'(busy), 32'(bz));
        check_eq({tag, "_done"}, 32'(done), 32'(dn));
    endtask

    task automatic load_word(input logic [3:0] a, input logic [15:0] ins,
                             input logic [7:0] x, input logic [7:0] y, input bit track);
        load_en    = 1'b1;
        load_addr  = a;
        load_instr = ins;
        load_d0    = x;
        load_d1    = y;
        tick();
        load_en = 1'b0;
        if (track) begin
            m_instr[a] = ins;
            m_d0[a]    = x;
            m_d1[a]    = y;
        end
    endtask

    task automatic start_prog(input logic [4:0] len);
        start    = 1'b1;
        prog_len = len;
        tick();
        start = 1'b0;
    endtask

    // Runs with ready high until done, bounded.
    task automatic run_to_done(input string tag);
        int k;
        exec_ready = 1'b1;
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        check_eq({tag, "_reached_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        int cnt;
        rst_n      = 1'b0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_instr = '0;
        load_d0    = '0;
        load_d1    = '0;
        start      = 1'b0;
        prog_len   = '0;
        abort      = 1'b0;
        exec_ready = 1'b0;

        #12;
        check_word("reset", 1'b0, 4'd0, 16'h0, 8'h0, 8'h0);
        check_flags("reset", 1'b0, 1'b0);
        #5 rst_n = 1'b1;
        tick();

        load_word(4'd0, 16'hffff, 8'd255, 8'd255, 1'b1);
        load_word(4'd1, 16'h0800, 8'd1, 8'd1, 1'b1);
        load_word(4'd2, 16'h0800, 8'd2, 8'd3, 1'b1);

        // Basic three-word program, back to back.
        exec_ready = 1'b1;
        start_prog(5'd3);
        check_word("run_w0", 1'b1, 4'd0, 16'hffff, 8'd255, 8'd255);
        check_flags("run_w0", 1'b1, 1'b0);
        tick();
        check_word("run_w1", 1'b1, 4'd1, 16'h0800, 8'd1, 8'd1);
        tick();
        check_word("run_w2", 1'b1, 4'd2, 16'h0800, 8'd2, 8'd3);
        tick();
        check_word("run_end", 1'b0, 4'd2, 16'h0, 8'h0, 8'h0);
        check_flags("run_end", 1'b0, 1'b1);
        tick();
        check_flags("run_hold", 1'b0, 1'b1);
        check_eq("run_hold_valid", 32'(issue_valid), 32'd0);

        // Stall four cycles at pc=1.
        start_prog(5'd3);
        check_word("stall_w0", 1'b1, 4'd0, 16'hffff, 8'd255, 8'd255);
        tick();
        exec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_word("stall_hold", 1'b1, 4'd1, 16'h0800, 8'd1, 8'd1);
        end
        exec_ready = 1'b1;
        tick();
        check_word("stall_w2", 1'b1, 4'd2, 16'h0800, 8'd2, 8'd3);
        tick();
        check_flags("stall_end", 1'b0, 1'b1);

        // Zero-length program.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_flags("abort_done", 1'b0, 1'b0);
        start_prog(5'd0);
        check_word("len0", 1'b0, 4'd0, 16'h0, 8'h0, 8'h0);
        check_flags("len0", 1'b0, 1'b1);

        // Fill the rest and run with an oversized length.
        for (int i = 3; i < 16; i++) begin
            load_word(4'(i), 16'h1000 + 16'(i), 8'(i), 8'(8'hf0 ^ 8'(i)), 1'b1);
        end
        start_prog(5'd20);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!issue_valid) break;
            check_eq("len20_pc", 32'(pc), 32'(cnt));
            check_eq("len20_instr", 32'(instruction), 32'(m_instr[cnt[3:0]]));
            check_eq("len20_d1", 32'(data1), 32'(m_d1[cnt[3:0]]));
            cnt++;
            tick();
        end
        check_eq("len20_count", 32'(cnt), 32'd16);
        check_eq("len20_last_pc", 32'(pc), 32'd15);
        check_flags("len20_end", 1'b0, 1'b1);

        // Abort together with a transfer at pc=1.
        start_prog(5'd3);
        tick();
        check_eq("abort_pre_pc", 32'(pc), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_word("abort", 1'b0, 4'd0, 16'h0, 8'h0, 8'h0);
        check_flags("abort", 1'b0, 1'b0);
        start_prog(5'd3);
        check_word("abort_rerun", 1'b1, 4'd0, 16'hffff, 8'd255, 8'd255);
        run_to_done("abort_rerun");

        // Load during RUN must be ignored.
        exec_ready = 1'b0;
        start_prog(5'd3);
        load_word(4'd0, 16'haaaa, 8'h11, 8'h22, 1'b0);
        check_word("runload_hold", 1'b1, 4'd0, 16'hffff, 8'd255, 8'd255);
        run_to_done("runload");
        start_prog(5'd3);
        check_word("runload_rerun", 1'b1, 4'd0, 16'hffff, 8'd255, 8'd255);
        run_to_done("runload_rerun");

        // Load in DONE takes effect.
        load_word(4'd0, 16'haaaa, 8'h11, 8'h22, 1'b1);
        start_prog(5'd3);
        check_word("doneload", 1'b1, 4'd0, 16'haaaa, 8'h11, 8'h22);
        tick();
        check_word("doneload_w1", 1'b1, 4'd1, 16'h0800, 8'd1, 8'd1);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        check_word("areset", 1'b0, 4'd0, 16'h0, 8'h0, 8'h0);
        check_flags("areset", 1'b0, 1'b0);
        #13 rst_n = 1'b1;
        tick();
        start_prog(5'd3);
        check_word("post_reset_w0", 1'b1, 4'd0, 16'haaaa, 8'h11, 8'h22);
        tick();
        check_word("post_reset_w1", 1'b1, 4'd1, 16'h0800, 8'd1, 8'd1);
        tick();
        check_word("post_reset_w2", 1'b1, 4'd2, 16'h0800, 8'd2, 8'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
